reflet_irq_ctrl: RTL and testbench



---
 rtl/reflet_irq_ctrl_pkg.sv | 30 +++
 rtl/reflet_irq_ctrl_if.sv | 39 +++
 rtl/reflet_irq_ctrl_line.sv | 93 +++++++++
 rtl/reflet_irq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_reflet_irq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reflet_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reflet_irq_ctrl_pkg
//   Shared definitions for the interrupt request controller:
//   - register select codes for the configuration port
//   - per-line FSM state type
//   - helper that formats one CLAIM nibble
// ---------------------------------------------------------------------------
package reflet_irq_ctrl_pkg;

  localparam int num_lines = 4;

  localparam logic [2:0] irq_reg_enable  = 3'd0;
  localparam logic [2:0] irq_reg_edge    = 3'd1;
  localparam logic [2:0] irq_reg_pending = 3'd2;
  localparam logic [2:0] irq_reg_route   = 3'd3;
  localparam logic [2:0] irq_reg_claim   = 3'd4;
  localparam logic [2:0] irq_reg_raw     = 3'd5;

  typedef enum logic [1:0] {
    irq_idle   = 2'd0,
    irq_req    = 2'd1,
    irq_active = 2'd2
  } line_state_e;

  // {active, src_id}; an idle line reads as all zeros.
  function automatic logic [3:0] claim_nibble(input logic busy, input logic [2:0] src);
    return busy ? {1'b1, src} : 4'h0;
  endfunction

endpackage

// File: rtl/reflet_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// reflet_irq_ctrl_if
//   CPU-side signals of the interrupt controller: the ack/eoi strobes from the
//   CPU interrupt unit and the word-wide configuration register port.
//
//   Handshake: every strobe (ack_valid, eoi_valid, cfg_we, cfg_re) is a
//   single-cycle valid pulse with no ready; the controller always accepts it
//   on the clock edge where it is high. The qualifier fields (ack_line,
//   eoi_line, cfg_addr, cfg_wdata) only matter while their strobe is high.
//   cfg_rdata is registered: it updates on the edge that samples cfg_re and
//   holds until the next read.
//
//   master: CPU / bus side      slave: reflet_irq_ctrl
// ---------------------------------------------------------------------------
interface reflet_irq_ctrl_if #(
  parameter int wordsize = 16
);
  logic                ack_valid;
  logic [1:0]          ack_line;
  logic                eoi_valid;
  logic [1:0]          eoi_line;
  logic [2:0]          cfg_addr;
  logic                cfg_we;
  logic                cfg_re;
  logic [wordsize-1:0] cfg_wdata;
  logic [wordsize-1:0] cfg_rdata;

  modport master (
    output ack_valid, ack_line, eoi_valid, eoi_line,
    output cfg_addr, cfg_we, cfg_re, cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  ack_valid, ack_line, eoi_valid, eoi_line,
    input  cfg_addr, cfg_we, cfg_re, cfg_wdata,
    output cfg_rdata
  );
endinterface

// File: rtl/reflet_irq_ctrl_line.sv
// ---------------------------------------------------------------------------
// reflet_irq_line
//   One CPU interrupt line: picks the lowest-index candidate source, raises
//   req until the CPU acknowledges, then holds the claim until end-of-interrupt.
//
//   Ports:
//     clk, reset   clock, async active-low reset
//     cand         sources eligible for this line (pending, enabled, routed
//                  here, not claimed by any line)
//     live         pending & enable for every source; a waiting claim is
//                  cancelled when its bit drops
//     ack, eoi     CPU ack / end-of-interrupt addressed to this line
//     req          registered request to the CPU (ext_int bit)
//     busy         line holds a claim (REQ or ACTIVE)
//     take         ack accepted this cycle (clears an edge source's pending)
//     src_id       claimed source index
//     state        FSM state, exported for observation
// ---------------------------------------------------------------------------
module reflet_irq_line
  import reflet_irq_ctrl_pkg::*;
#(
  parameter int nsrc = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [nsrc-1:0] cand,
  input  logic [nsrc-1:0] live,
  input  logic            ack,
  input  logic            eoi,
  output logic            req,
  output logic            busy,
  output logic            take,
  output logic [2:0]      src_id,
  output line_state_e     state
);

  logic [2:0] win_id;
  logic       win_any;
  logic [7:0] live_w;

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    win_id  = 3'd0;
    win_any = 1'b0;
    for (int i = nsrc - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_id  = 3'(i);
        win_any = 1'b1;
      end
    end
  end

  // Widen so a 3-bit src_id can always index it, whatever nsrc is.
  assign live_w = 8'(live);
  assign busy   = (state != irq_idle);
  assign take   = (state == irq_req) && ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= irq_idle;
      src_id <= 3'd0;
      req    <= 1'b0;
    end else begin
      case (state)
        irq_idle: begin
          if (win_any) begin
            state  <= irq_req;
            src_id <= win_id;
            req    <= 1'b1;
          end
        end
        irq_req: begin
          // Ack has priority over a cancel seen in the same cycle.
          if (ack) begin
            state <= irq_active;
            req   <= 1'b0;
          end else if (!live_w[src_id]) begin
            state <= irq_idle;
            req   <= 1'b0;
          end
        end
        irq_active: begin
          if (eoi) state <= irq_idle;
        end
        default: begin
          state <= irq_idle;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reflet_irq_ctrl.sv
// ---------------------------------------------------------------------------
// reflet_irq_ctrl
//   Interrupt request controller in front of the CPU's 4-line ext_int input.
//   Synchronises nsrc peripheral requests, keeps per-source pending state
//   (edge or level), routes each source to one of four lines and runs one
//   claim/ack/eoi FSM per line.
//
//   Ports:
//     clk             system clock, rising edge
//     reset           asynchronous active-low reset
//     src_irq         raw peripheral requests, asynchronous to clk
//     ext_int         registered requests to the CPU interrupt unit
//     dbg_line_state  2 bits per line, FSM state of each line
//     bus             ack/eoi strobes and configuration port (slave side)
//
//   Register map (upper bits read 0):
//     0 ENABLE  1 EDGE  2 PENDING (W1C, edge sources)  3 ROUTE (2 bits/src)
//     4 CLAIM (nibble k = {active, src_id} of line k)  5 RAW  6,7 zero
// ---------------------------------------------------------------------------
module reflet_irq_ctrl
  import reflet_irq_ctrl_pkg::*;
#(
  parameter int wordsize    = 16,
  parameter int nsrc        = 8,
  parameter int sync_stages = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [nsrc-1:0]          src_irq,
  output logic [3:0]               ext_int,
  output logic [2*num_lines-1:0]   dbg_line_state,
  reflet_irq_ctrl_if.slave         bus
);

  logic [sync_stages-1:0][nsrc-1:0] sync_pipe;
  logic [nsrc-1:0]   sync;
  logic [nsrc-1:0]   sync_d;
  logic [nsrc-1:0]   enable_q;
  logic [nsrc-1:0]   edge_q;
  logic [nsrc-1:0]   pending_q;
  logic [2*nsrc-1:0] route_q;

  logic [nsrc-1:0]   w1c;
  logic [nsrc-1:0]   edge_set;
  logic [nsrc-1:0]   ack_clr;
  logic [nsrc-1:0]   claimed;
  logic [nsrc-1:0]   live;
  logic [nsrc-1:0]   pending_nxt;
  logic [7:0]        claimed_w;
  logic [7:0]        ack_clr_w;

  logic [num_lines-1:0][nsrc-1:0] line_cand;
  logic [num_lines-1:0] line_req;
  logic [num_lines-1:0] line_busy;
  logic [num_lines-1:0] line_take;
  logic [num_lines-1:0] line_ack;
  logic [num_lines-1:0] line_eoi;
  logic [2:0]           line_src   [num_lines];
  line_state_e          line_state [num_lines];

  logic [wordsize-1:0] rd_word;

  // -------------------------------------------------------------------------
  // Synchronisers: stage 0 takes the raw input, the last stage is the
  // clean level. sync_d is one more delay for rising-edge detection.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_pipe <= '0;
      sync_d    <= '0;
    end else begin
      sync_pipe <= {sync_pipe[sync_stages-2:0], src_irq};
      sync_d    <= sync;
    end
  end

  assign sync = sync_pipe[sync_stages-1];

  // -------------------------------------------------------------------------
  // Configuration registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= '0;
      edge_q   <= '0;
      route_q  <= '0;
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        irq_reg_enable: enable_q <= bus.cfg_wdata[nsrc-1:0];
        irq_reg_edge:   edge_q   <= bus.cfg_wdata[nsrc-1:0];
        irq_reg_route:  route_q  <= bus.cfg_wdata[2*nsrc-1:0];
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pending. Level sources simply follow the enabled synchronised level.
  // Edge sources latch a rising edge; W1C or the ack of their claim clears
  // them, and a new edge in the same cycle beats the clear.
  // -------------------------------------------------------------------------
  assign w1c      = (bus.cfg_we && bus.cfg_addr == irq_reg_pending)
                    ? bus.cfg_wdata[nsrc-1:0] : '0;
  assign edge_set = sync & ~sync_d & enable_q;

  assign pending_nxt = (edge_q & (edge_set | (pending_q & ~(w1c | ack_clr))))
                     | (~edge_q & sync & enable_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_nxt;
  end

  assign live = pending_q & enable_q;

  // Sources held by any line, and sources whose claim is acked this cycle.
  // A source rerouted while claimed stays excluded until its claim ends.
  always_comb begin
    claimed_w = 8'd0;
    ack_clr_w = 8'd0;
    for (int k = 0; k < num_lines; k++) begin
      if (line_busy[k]) claimed_w[line_src[k]] = 1'b1;
      if (line_take[k]) ack_clr_w[line_src[k]] = 1'b1;
    end
  end

  assign claimed = claimed_w[nsrc-1:0];
  assign ack_clr = ack_clr_w[nsrc-1:0];

  always_comb begin
    line_cand = '0;
    for (int k = 0; k < num_lines; k++) begin
      for (int i = 0; i < nsrc; i++) begin
        line_cand[k][i] = live[i] & ~claimed[i] & (route_q[2*i +: 2] == 2'(k));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-line FSMs
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < num_lines; k++) begin : g_line
    assign line_ack[k] = bus.ack_valid && (bus.ack_line == 2'(k));
    assign line_eoi[k] = bus.eoi_valid && (bus.eoi_line == 2'(k));

    reflet_irq_line #(
      .nsrc (nsrc)
    ) u_line (
      .clk    (clk),
      .reset  (reset),
      .cand   (line_cand[k]),
      .live   (live),
      .ack    (line_ack[k]),
      .eoi    (line_eoi[k]),
      .req    (line_req[k]),
      .busy   (line_busy[k]),
      .take   (line_take[k]),
      .src_id (line_src[k]),
      .state  (line_state[k])
    );

    assign dbg_line_state[2*k +: 2] = line_state[k];
  end

  assign ext_int = line_req;

  // -------------------------------------------------------------------------
  // Read-back, registered on cfg_re and held otherwise
  // -------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    case (bus.cfg_addr)
      irq_reg_enable:  rd_word[nsrc-1:0]   = enable_q;
      irq_reg_edge:    rd_word[nsrc-1:0]   = edge_q;
      irq_reg_pending: rd_word[nsrc-1:0]   = pending_q;
      irq_reg_route:   rd_word[2*nsrc-1:0] = route_q;
      irq_reg_claim: begin
        for (int k = 0; k < num_lines; k++) begin
          rd_word[4*k +: 4] = claim_nibble(line_busy[k], line_src[k]);
        end
      end
      irq_reg_raw:     rd_word[nsrc-1:0]   = sync;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          bus.cfg_rdata <= '0;
    else if (bus.cfg_re) bus.cfg_rdata <= rd_word;
  end

endmodule

// File: tb/tb_reflet_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reflet_irq_ctrl
//   Directed scenarios followed by a randomized run. A behavioural model of
//   the controller (sample history, per-source pending bits, per-line mode)
//   predicts ext_int and cfg_rdata every cycle.
// ---------------------------------------------------------------------------
module tb_reflet_irq_ctrl;

  localparam int NS = 8;
  localparam int SS = 2;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [7:0] src_irq;
  logic [3:0] ext_int;
  logic [7:0] dbg_line_state;

  reflet_irq_ctrl_if #(.wordsize(16)) bus ();

  reflet_irq_ctrl #(
    .wordsize    (16),
    .nsrc        (NS),
    .sync_stages (SS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .src_irq        (src_irq),
    .ext_int        (ext_int),
    .dbg_line_state (dbg_line_state),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_en, m_edge, m_pend, m_sync, m_sync_d;
  logic [15:0] m_route;
  logic [7:0]  m_samp [$];
  int          m_mode [4];   // 0 = free, 1 = waiting for ack, 2 = in service
  int          m_src  [4];
  logic [3:0]  m_ext;
  logic [15:0] m_rdata;

  task automatic model_reset();
    m_en = 0; m_edge = 0; m_pend = 0; m_sync = 0; m_sync_d = 0;
    m_route = 0; m_ext = 0; m_rdata = 0;
    m_samp.delete();
    for (int s = 0; s < SS; s++) m_samp.push_back(8'h00);
    for (int k = 0; k < 4; k++) begin
      m_mode[k] = 0;
      m_src[k]  = 0;
    end
  endtask

  function automatic int route_of(input int i);
    return int'((m_route >> (2 * i)) & 16'h3);
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] a);
    logic [15:0] v;
    v = 0;
    case (a)
      3'd0: v = {8'h00, m_en};
      3'd1: v = {8'h00, m_edge};
      3'd2: v = {8'h00, m_pend};
      3'd3: v = m_route;
      3'd4: for (int k = 0; k < 4; k++)
              if (m_mode[k] != 0) v = v | (16'((8 + m_src[k])) << (4 * k));
      3'd5: v = {8'h00, m_sync};
      default: v = 0;
    endcase
    return v;
  endfunction

  // One clock edge of the model, using the inputs driven for this edge.
  task automatic model_step();
    logic [7:0]  live, claimed, ack_clr, nxt_pend;
    logic [3:0]  nxt_ext;
    logic [15:0] nxt_rd;
    int          nmode [4];
    int          nsel  [4];
    logic        set_b, clr_b;
    if (!reset) begin
      model_reset();
      return;
    end
    live    = m_pend & m_en;
    claimed = 0;
    ack_clr = 0;
    for (int k = 0; k < 4; k++) if (m_mode[k] != 0) claimed[m_src[k]] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nmode[k]   = m_mode[k];
      nsel[k]    = m_src[k];
      nxt_ext[k] = m_ext[k];
      if (m_mode[k] == 0) begin
        for (int i = 0; i < NS; i++) begin
          if (nmode[k] == 0 && live[i] && route_of(i) == k && !claimed[i]) begin
            nmode[k] = 1; nsel[k] = i; nxt_ext[k] = 1'b1;
          end
        end
      end else if (m_mode[k] == 1) begin
        if (bus.ack_valid && int'(bus.ack_line) == k) begin
          nmode[k] = 2; nxt_ext[k] = 1'b0; ack_clr[m_src[k]] = 1'b1;
        end else if (!live[m_src[k]]) begin
          nmode[k] = 0; nxt_ext[k] = 1'b0;
        end
      end else begin
        if (bus.eoi_valid && int'(bus.eoi_line) == k) nmode[k] = 0;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (m_edge[i]) begin
        set_b = m_sync[i] && !m_sync_d[i] && m_en[i];
        clr_b = (bus.cfg_we && bus.cfg_addr == 3'd2 && bus.cfg_wdata[i]) || ack_clr[i];
        nxt_pend[i] = set_b || (m_pend[i] && !clr_b);
      end else begin
        nxt_pend[i] = m_sync[i] && m_en[i];
      end
    end
    nxt_rd = bus.cfg_re ? model_read(bus.cfg_addr) : m_rdata;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        3'd0: m_en    = bus.cfg_wdata[7:0];
        3'd1: m_edge  = bus.cfg_wdata[7:0];
        3'd3: m_route = bus.cfg_wdata;
        default: ;
      endcase
    end
    m_pend  = nxt_pend;
    m_ext   = nxt_ext;
    m_rdata = nxt_rd;
    for (int k = 0; k < 4; k++) begin
      m_mode[k] = nmode[k];
      m_src[k]  = nsel[k];
    end
    m_samp.push_front(src_irq);
    void'(m_samp.pop_back());
    m_sync_d = m_sync;
    m_sync   = m_samp[SS-1];
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are driven at the falling edge; the model advances on the rising
  // edge; outputs are compared on the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.ack_valid = 0;
    bus.eoi_valid = 0;
    bus.cfg_we    = 0;
    bus.cfg_re    = 0;
    check("ext_int", 32'(ext_int), 32'(m_ext));
    check("cfg_rdata", 32'(bus.cfg_rdata), 32'(m_rdata));
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.cfg_addr = a; bus.cfg_wdata = d; bus.cfg_we = 1;
    tick();
  endtask

  task automatic rd(input logic [2:0] a);
    bus.cfg_addr = a; bus.cfg_re = 1;
    tick();
  endtask

  task automatic ack(input logic [1:0] l);
    bus.ack_line = l; bus.ack_valid = 1;
    tick();
  endtask

  task automatic eoi(input logic [1:0] l);
    bus.eoi_line = l; bus.eoi_valid = 1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 0; src_irq = 0;
    bus.ack_valid = 0; bus.ack_line = 0; bus.eoi_valid = 0; bus.eoi_line = 0;
    bus.cfg_addr = 0; bus.cfg_we = 0; bus.cfg_re = 0; bus.cfg_wdata = 0;
    model_reset();
    #1;
    check("rst_ext_int", 32'(ext_int), 32'h0);
    check("rst_rdata", 32'(bus.cfg_rdata), 32'h0);
    tick(); tick();
    reset = 1;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("rst_reg", 32'(bus.cfg_rdata), 32'h0);
    end

    // Edge source 0 on line 0: latency, pending, claim.
    wr(3'd0, 16'h0001); wr(3'd1, 16'h0001); wr(3'd3, 16'h0000);
    src_irq = 8'h01; tick();          // edge E samples the pulse
    src_irq = 8'h00; tick(); tick();  // E+1, E+2
    check("lat_e2", 32'(ext_int[0]), 32'h0);
    tick();                           // E+3
    check("lat_e3", 32'(ext_int[0]), 32'h1);
    rd(3'd2); check("pend_edge", 32'(bus.cfg_rdata), 32'h0001);
    rd(3'd4); check("claim_req", 32'(bus.cfg_rdata), 32'h0008);

    // Ack, then eoi.
    ack(2'd0);
    check("ack_drop", 32'(ext_int[0]), 32'h0);
    rd(3'd2); check("pend_acked", 32'(bus.cfg_rdata), 32'h0000);
    rd(3'd4); check("claim_active", 32'(bus.cfg_rdata), 32'h0008);
    eoi(2'd0);
    rd(3'd4); check("claim_eoi", 32'(bus.cfg_rdata), 32'h0000);

    // Two level sources sharing line 1: lowest index first.
    wr(3'd1, 16'h0000); wr(3'd0, 16'h000C); wr(3'd3, 16'h0050);
    src_irq = 8'h0C;
    repeat (5) tick();
    check("share_ext", 32'(ext_int), 32'h2);
    rd(3'd4); check("claim_src2", 32'(bus.cfg_rdata), 32'h00A0);
    ack(2'd1);
    src_irq = 8'h08;
    repeat (4) tick();
    eoi(2'd1);
    tick();
    rd(3'd4); check("claim_src3", 32'(bus.cfg_rdata), 32'h00B0);
    src_irq = 8'h00;
    repeat (5) tick();
    check("share_clear", 32'(ext_int), 32'h0);

    // Level source 5 on line 3, released before ack.
    wr(3'd0, 16'h0020); wr(3'd3, 16'h0C00);
    src_irq = 8'h20;
    for (int n = 0; n < 10 && !ext_int[3]; n++) tick();
    check("l3_wait", 32'(ext_int[3]), 32'h1);
    rd(3'd4); check("claim_src5", 32'(bus.cfg_rdata), 32'hD000);
    src_irq = 8'h00;
    repeat (5) tick();
    check("l3_cancel", 32'(ext_int[3]), 32'h0);
    rd(3'd4); check("claim_cancel", 32'(bus.cfg_rdata), 32'h0000);

    // Edge source 1: W1C colliding with a new rising edge keeps the request.
    wr(3'd0, 16'h0002); wr(3'd1, 16'h0002); wr(3'd3, 16'h0000);
    src_irq = 8'h02; tick();
    src_irq = 8'h00;
    repeat (3) tick();
    check("e1_req", 32'(ext_int[0]), 32'h1);
    src_irq = 8'h02; tick();          // E
    src_irq = 8'h00; tick();          // E+1
    wr(3'd2, 16'h0002);               // E+2: edge sets while W1C clears
    tick();
    check("w1c_set_wins", 32'(ext_int[0]), 32'h1);
    rd(3'd2); check("pend_kept", 32'(bus.cfg_rdata), 32'h0002);
    wr(3'd2, 16'h0002);               // plain W1C cancels the waiting claim
    tick();
    check("w1c_cancel", 32'(ext_int[0]), 32'h0);

    // Lines 0 and 2 in service, line 1 waiting, then async reset.
    wr(3'd1, 16'h0000); wr(3'd0, 16'h0007); wr(3'd3, 16'h0018);
    src_irq = 8'h07;
    repeat (5) tick();
    check("three_lines", 32'(ext_int), 32'h7);
    ack(2'd0);
    ack(2'd2);
    check("two_active", 32'(ext_int), 32'h2);
    rd(3'd0); check("en_before_rst", 32'(bus.cfg_rdata), 32'h0007);
    #2 reset = 0;
    #1;
    check("async_ext", 32'(ext_int), 32'h0);
    check("async_rdata", 32'(bus.cfg_rdata), 32'h0);
    model_reset();
    src_irq = 8'h00;
    tick(); tick();
    reset = 1;
    repeat (3) tick();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("post_rst_reg", 32'(bus.cfg_rdata), 32'h0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 7) == 0) src_irq[i] = ~src_irq[i];
      if ($urandom_range(0, 3) == 0) begin
        bus.ack_valid = 1; bus.ack_line = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 4) == 0) begin
        bus.eoi_valid = 1; bus.eoi_line = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) begin
        bus.cfg_we = 1; bus.cfg_addr = 3'($urandom_range(0, 7));
        bus.cfg_wdata = 16'($urandom);
      end else if ($urandom_range(0, 2) == 0) begin
        bus.cfg_re = 1; bus.cfg_addr = 3'($urandom_range(0, 7));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
